// File: rtl/pc_unit_mt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pc_unit_mt                                                 |
// | Description : Multi-hart program counter with round-robin hart selection,|
// |               per-hart redirect and optional misaligned-redirect trap    |
// |               (enabled by defining PC_MISALIGN_TRAP_EN).                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pc_unit_mt #(
   parameter int          XLEN         = 64,
   parameter int          NUM_HARTS    = 2,
   parameter logic [63:0] RESET_VECTOR = 64'd0,
   parameter logic [63:0] TRAP_VECTOR  = 64'h100,
   localparam int         HART_W       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 PCWrite,
   input  logic [NUM_HARTS-1:0] Hart_En,
   input  logic                 Redirect_Valid,
   input  logic [HART_W-1:0]    Redirect_Hart,
   input  logic [XLEN-1:0]      Redirect_PC,
   output logic [XLEN-1:0]      PC_Out,
   output logic [HART_W-1:0]    Hart_Out,
   output logic                 PC_Valid,
   output logic                 Misalign_Trap,
   output logic [HART_W-1:0]    Misalign_Hart
);

   localparam logic [XLEN-1:0]   c_reset_pc  = RESET_VECTOR[XLEN-1:0];
   localparam logic [XLEN-1:0]   c_trap_pc   = TRAP_VECTOR[XLEN-1:0];
   localparam logic [XLEN-1:0]   c_pc_step   = XLEN'(4);
   localparam logic [HART_W:0]   c_num_harts = (HART_W+1)'(NUM_HARTS);

   logic [XLEN-1:0]   r_pc [NUM_HARTS];
   logic [HART_W-1:0] r_hart;

   logic [XLEN-1:0]   w_pc_out;
   logic              w_pc_valid;
   logic              w_step;
   logic              w_redir_ok;
   logic              w_misaligned;
   logic [XLEN-1:0]   w_redir_target;
   logic [HART_W-1:0] w_next_hart;
   logic [HART_W-1:0] w_hi_hart;
   logic [HART_W-1:0] w_lo_hart;
   logic              w_hi_found;

   // Selected hart's PC and enable, muxed so out-of-range pointer codes read as zero
   always_comb begin
      w_pc_out   = '0;
      w_pc_valid = 1'b0;
      for (int h = 0; h < NUM_HARTS; h++) begin
         if (r_hart == HART_W'(h)) begin
            w_pc_out   = r_pc[h];
            w_pc_valid = Hart_En[h];
         end
      end
   end

   // Next enabled hart above the current one, else the lowest enabled hart overall
   always_comb begin
      w_hi_hart  = r_hart;
      w_lo_hart  = r_hart;
      w_hi_found = 1'b0;
      for (int h = NUM_HARTS - 1; h >= 0; h--) begin
         if (Hart_En[h]) begin
            w_lo_hart = HART_W'(h);
            if (HART_W'(h) > r_hart) begin
               w_hi_hart  = HART_W'(h);
               w_hi_found = 1'b1;
            end
         end
      end
      if (w_hi_found) begin
         w_next_hart = w_hi_hart;
      end else if (|Hart_En) begin
         w_next_hart = w_lo_hart;
      end else begin
         w_next_hart = r_hart;
      end
   end

   assign w_step       = PCWrite & w_pc_valid;
   assign w_redir_ok   = Redirect_Valid & ({1'b0, Redirect_Hart} < c_num_harts);
   assign w_misaligned = (Redirect_PC[1:0] != 2'b00);

`ifdef PC_MISALIGN_TRAP_EN
   logic              r_trap;
   logic [HART_W-1:0] r_trap_hart;

   assign w_redir_target = w_misaligned ? c_trap_pc : Redirect_PC;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_trap      <= 1'b0;
         r_trap_hart <= '0;
      end else begin
         r_trap <= w_redir_ok & w_misaligned;
         if (w_redir_ok && w_misaligned) begin
            r_trap_hart <= Redirect_Hart;
         end
      end
   end

   assign Misalign_Trap = r_trap;
   assign Misalign_Hart = r_trap_hart;
`else
   logic w_unused_trap;

   // Misaligned targets are silently rounded down to a word boundary
   assign w_redir_target = {Redirect_PC[XLEN-1:2], 2'b00};
   assign w_unused_trap  = ^{c_trap_pc, w_misaligned};
   assign Misalign_Trap  = 1'b0;
   assign Misalign_Hart  = '0;
`endif

   // Redirect has priority over the sequential step for the same hart
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int h = 0; h < NUM_HARTS; h++) begin
            r_pc[h] <= c_reset_pc;
         end
         r_hart <= '0;
      end else begin
         for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_redir_ok && (Redirect_Hart == HART_W'(h))) begin
               r_pc[h] <= w_redir_target;
            end else if (w_step && (r_hart == HART_W'(h))) begin
               r_pc[h] <= r_pc[h] + c_pc_step;
            end
         end
         if (PCWrite) begin
            r_hart <= w_next_hart;
         end
      end
   end

   assign PC_Out   = w_pc_out;
   assign Hart_Out = r_hart;
   assign PC_Valid = w_pc_valid;

endmodule
`default_nettype wire
